// File: rtl/bwt_search_engine.sv
// -----------------------------------------------------------------------------
// bwt_search_engine
//
// BWT backward search. On start_i the engine walks the query from its last
// symbol to its first. For each symbol it narrows the half-open suffix-array
// interval [lo,hi) using one C-table read and a dual Occ read. When the final
// interval is non-empty it reads up to MAX_HITS suffix-array entries starting
// at lo and streams them as reference locations over a valid/ready port. It
// then pulses done_o with found_o/hit_count_o.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i, qlen_i         query start pulse and length (sampled in IDLE)
//   busy_o                  engine occupied (cycle after start .. done cycle)
//   q_rd_*                  query memory read, 1-cycle latency
//   c_rd_*                  C table read, 1-cycle latency
//   occ_*                   dual Occ(sym, addr) read, 1-cycle latency
//   sa_rd_*                 suffix array read, 1-cycle latency
//   loc_valid_o/ready_i     location stream handshake; loc_o, loc_last_o data
//   done_o                  1-cycle completion pulse
//   found_o, hit_count_o    result, held from done_o until the next start
// -----------------------------------------------------------------------------
module bwt_search_engine #(
  parameter int REF_NUM     = 1024,
  parameter int REF_LENGTH  = 10,
  parameter int TAGT_LENGTH = 5,
  parameter int MAX_HITS    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [TAGT_LENGTH:0]   qlen_i,
  output logic                   busy_o,
  output logic                   q_rd_en_o,
  output logic [TAGT_LENGTH-1:0] q_rd_addr_o,
  input  logic [1:0]             q_rd_data_i,
  output logic                   c_rd_en_o,
  output logic [1:0]             c_rd_addr_o,
  input  logic [REF_LENGTH:0]    c_rd_data_i,
  output logic                   occ_rd_en_o,
  output logic [1:0]             occ_sym_o,
  output logic [REF_LENGTH:0]    occ_addr0_o,
  output logic [REF_LENGTH:0]    occ_addr1_o,
  input  logic [REF_LENGTH:0]    occ_data0_i,
  input  logic [REF_LENGTH:0]    occ_data1_i,
  output logic                   sa_rd_en_o,
  output logic [REF_LENGTH-1:0]  sa_rd_addr_o,
  input  logic [REF_LENGTH-1:0]  sa_rd_data_i,
  output logic                   loc_valid_o,
  input  logic                   loc_ready_i,
  output logic [REF_LENGTH-1:0]  loc_o,
  output logic                   loc_last_o,
  output logic                   done_o,
  output logic                   found_o,
  output logic [REF_LENGTH:0]    hit_count_o
);

  localparam int W = REF_LENGTH + 1;
  localparam logic [W-1:0]           REF_NUM_W  = W'(REF_NUM);
  localparam logic [W-1:0]           MAX_HITS_W = W'(MAX_HITS);
  localparam logic [TAGT_LENGTH:0]   QLEN_MAX   = (TAGT_LENGTH+1)'(2**TAGT_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE, S_QRD, S_SYM, S_UPD, S_SARD, S_SACAP, S_SAOUT, S_FIN
  } state_t;

  state_t                 state_q;
  logic [W-1:0]           lo_q, hi_q;
  logic [TAGT_LENGTH-1:0] pos_q;
  logic [W-1:0]           idx_q;
  logic [W-1:0]           last_idx_q;   // min(count, MAX_HITS) - 1
  logic [W-1:0]           count_q;

  logic                   busy_q, q_rd_en_q, c_rd_en_q, sa_rd_en_q;
  logic                   loc_valid_q, loc_last_q, done_q, found_q;
  logic [REF_LENGTH-1:0]  loc_q;
  logic [W-1:0]           hit_count_q;

  // Next interval bounds, valid during UPD when the C/Occ data has arrived.
  logic [W-1:0]           lo_d, hi_d, count_d;
  logic [TAGT_LENGTH-1:0] pos_d;

  assign lo_d    = c_rd_data_i + occ_data0_i;
  assign hi_d    = c_rd_data_i + occ_data1_i;
  assign count_d = hi_d - lo_d;
  // Over-long queries are clamped to the full query memory.
  assign pos_d   = (qlen_i > QLEN_MAX) ? '1 : TAGT_LENGTH'(qlen_i - 1'b1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      pos_q       <= '0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      q_rd_en_q   <= 1'b0;
      c_rd_en_q   <= 1'b0;
      sa_rd_en_q  <= 1'b0;
      loc_valid_q <= 1'b0;
      loc_last_q  <= 1'b0;
      loc_q       <= '0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      hit_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            found_q     <= 1'b0;
            hit_count_q <= '0;
            lo_q        <= '0;
            hi_q        <= REF_NUM_W;
            idx_q       <= '0;
            count_q     <= '0;
            if (qlen_i == '0) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              pos_q     <= pos_d;
              q_rd_en_q <= 1'b1;
              state_q   <= S_QRD;
            end
          end
        end
        S_QRD: begin
          q_rd_en_q <= 1'b0;
          c_rd_en_q <= 1'b1;
          state_q   <= S_SYM;
        end
        S_SYM: begin
          c_rd_en_q <= 1'b0;
          state_q   <= S_UPD;
        end
        S_UPD: begin
          lo_q <= lo_d;
          hi_q <= hi_d;
          if (lo_d >= hi_d) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else if (pos_q == '0) begin
            count_q    <= count_d;
            idx_q      <= '0;
            last_idx_q <= ((count_d > MAX_HITS_W) ? MAX_HITS_W : count_d) - 1'b1;
            sa_rd_en_q <= 1'b1;
            state_q    <= S_SARD;
          end else begin
            pos_q     <= pos_q - 1'b1;
            q_rd_en_q <= 1'b1;
            state_q   <= S_QRD;
          end
        end
        S_SARD: begin
          sa_rd_en_q <= 1'b0;
          state_q    <= S_SACAP;
        end
        S_SACAP: begin
          loc_q       <= sa_rd_data_i;
          loc_valid_q <= 1'b1;
          loc_last_q  <= (idx_q == last_idx_q);
          state_q     <= S_SAOUT;
        end
        S_SAOUT: begin
          if (loc_ready_i) begin
            loc_valid_q <= 1'b0;
            loc_last_q  <= 1'b0;
            if (loc_last_q) begin
              done_q      <= 1'b1;
              found_q     <= 1'b1;
              hit_count_q <= count_q;
              state_q     <= S_FIN;
            end else begin
              idx_q      <= idx_q + 1'b1;
              sa_rd_en_q <= 1'b1;
              state_q    <= S_SARD;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The symbol arrives from the query memory during SYM, so the C/Occ symbol
  // is taken straight from the read data; it is gated so it idles at zero.
  assign c_rd_addr_o  = q_rd_data_i & {2{c_rd_en_q}};
  assign occ_sym_o    = q_rd_data_i & {2{c_rd_en_q}};
  assign occ_addr0_o  = lo_q;
  assign occ_addr1_o  = hi_q;
  assign q_rd_addr_o  = pos_q;
  assign sa_rd_addr_o = REF_LENGTH'(lo_q + idx_q);

  assign busy_o       = busy_q;
  assign q_rd_en_o    = q_rd_en_q;
  assign c_rd_en_o    = c_rd_en_q;
  assign occ_rd_en_o  = c_rd_en_q;
  assign sa_rd_en_o   = sa_rd_en_q;
  assign loc_valid_o  = loc_valid_q;
  assign loc_o        = loc_q;
  assign loc_last_o   = loc_last_q;
  assign done_o       = done_q;
  assign found_o      = found_q;
  assign hit_count_o  = hit_count_q;

endmodule
